sev_seg_scan: RTL and testbench
===============================

# sev_seg_scan

Time-multiplexed, parametrised seven-segment driver for the elevator controller's floor/door display. It scans `NUM_DIGITS` common-anode digits, one slot at a time, with a blanking gap at the start of each slot. The digit for the current floor shows the door-open or door-closed glyph; all other digits are blank. The elevator FSM updates the block through a strobe, and the glyph optionally blinks while the car is moving.

## Interface
- `NUM_DIGITS`, default 4: number of digits/floors. Must be ≥ 2.
- `SCAN_DIV`, default 1000: clock cycles per digit slot. Must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 2: cycles at the start of each slot with `select` all-high (anti-ghosting). May be 0.
- `BLINK_FRAMES`, default 50: full scan frames per blink half-period. Must be ≥ 1.
- `FLOOR_W` (localparam): `$clog2(NUM_DIGITS)`.

Ports (clock and reset first):
- `clk`  input  1  system clock.
- `rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `update`  input  1  one-cycle strobe; samples `floor_sel` and `door_open`.
- `floor_sel`  input  `FLOOR_W`  floor index, 0-based.
- `door_open`  input  1  1 = door open glyph, 0 = door closed glyph.
- `moving`  input  1  car in motion. Used only when the blink feature is compiled in.
- `segments`  output  7  active-low segment pattern.
- `select`  output  `NUM_DIGITS`  active-low one-hot digit enable.
- `err`  output  1  one-cycle pulse when an `update` carries an out-of-range floor.

## Operation
- State registers:
  - `div_cnt`: 0..`SCAN_DIV`-1.
  - `scan_idx`: 0..`NUM_DIGITS`-1.
  - `frame_cnt`: 0..`BLINK_FRAMES`-1.
  - `blink_on`.
  - `floor_q`, `door_q`.
- Scan sequencing:
  - `div_cnt` increments every cycle.
  - At `SCAN_DIV`-1 it wraps to 0 and `scan_idx` advances.
  - `scan_idx` wraps from `NUM_DIGITS`-1 to 0. That wrap is the frame tick.
- Lit phase: `div_cnt >= BLANK_CYCLES`.
  - Lit: `select` drives bit `scan_idx` low, all other bits high.
  - Not lit: `select` is all ones.
- Segments:
  - `segments` = `GLYPH_DOOR_OPEN` (7'b1000011) or `GLYPH_DOOR_CLOSED` (7'b0100011), selected by `door_q`, only when lit, `scan_idx == floor_q` and the glyph is visible.
  - In every other case `segments` = `GLYPH_BLANK` (7'b1111111).
- Update handling:
  - If `floor_sel < NUM_DIGITS`, `floor_q` and `door_q` load on the next edge.
  - Otherwise both hold their values and `err` pulses high for one cycle.
  - `door_open` is also ignored on an invalid update.
- Simultaneous events:
  - An `update` coinciding with a slot or frame tick is applied together with the tick.
  - `rst` overrides `update` and all other activity.
- Reset values, all applied on the next edge: `div_cnt` = 0, `scan_idx` = 0, `frame_cnt` = 0, `blink_on` = 1, `floor_q` = 0, `door_q` = 0, `select` = all ones, `segments` = 7'b1111111, `err` = 0.
- Reset mid-scan discards the latched floor/door; the scan restarts at digit 0, slot cycle 0.

## Timing
- `segments`, `select` and `err` are registered. They reflect the state of the previous cycle.
- `update` at edge t → `floor_q` valid after t → new glyph on outputs from edge t+1, provided the slot is lit and `scan_idx` matches.
- Slot length is exactly `SCAN_DIV` cycles. The first `BLANK_CYCLES` cycles of each slot have `select` all ones.
- Frame length is `NUM_DIGITS`×`SCAN_DIV` cycles.
- `err` is high exactly one cycle per invalid `update`, starting one edge after the strobe.

## Configuration
- Macro `SEVSEG_BLINK_EN`.
- Defined:
  - While `moving` = 1, `blink_on` toggles every `BLINK_FRAMES` frame ticks. The glyph is visible only when `blink_on` = 1.
  - `moving` = 0 clears `frame_cnt` and forces `blink_on` = 1 on the next edge, so the glyph is steady.
- Undefined:
  - `frame_cnt` and `blink_on` are not built and `moving` is ignored.
  - The glyph is always visible.

## Structure
- `sev_seg_pkg` contains:
  - `GLYPH_DOOR_OPEN`, `GLYPH_DOOR_CLOSED`, `GLYPH_BLANK` as 7-bit constants.
  - A `glyph_t` typedef.
  - A function `onehot_n(idx, n)` that returns the active-low select vector.
- One sub-module, `sev_seg_scan_timer`, owns `div_cnt`, `scan_idx` and the frame counter. It exports `slot_tick`, `frame_tick`, `lit` and `scan_idx`.

## Test plan
Unless stated otherwise, parameters are `NUM_DIGITS`=4, `SCAN_DIV`=4, `BLANK_CYCLES`=1, `BLINK_FRAMES`=2.
- **Reset**: hold `rst` 2 cycles → `select`=4'b1111, `segments`=7'b1111111. After release, cycle 1 of slot 0 → `select`=4'b1110, `segments`=7'b0100011.
- **Scan order**: free-run 20 cycles → `select` sequence 1111,1110×3, 1111,1101×3, 1111,1011×3, 1111,0111×3, then wraps to 1110. `segments` is blank outside slot 0.
- **Valid update**: `update` with `floor_sel`=2, `door_open`=1 → in slot 2 lit cycles, `select`=4'b1011 and `segments`=7'b1000011. Slots 0, 1 and 3 show `segments`=7'b1111111.
- **Invalid update**: `NUM_DIGITS`=3 instance, `update` with `floor_sel`=3 → `err`=1 for exactly one cycle and the display is unchanged. `update` with `floor_sel`=2 → `err`=0 and the display moves to digit 2.
- **Blink** (`SEVSEG_BLINK_EN` defined, floor 1, `moving`=1):
  - Glyph visible for 2 frames (32 cycles), blank for 2 frames, repeating.
  - Drop `moving` during the blank half → glyph visible at the next lit cycle of slot 1.
  - Without the macro, the glyph stays steady.
- **Reset mid-scan**: assert `rst` in slot 2 with floor 3 / door open latched → next cycle outputs all ones. After release, the scan starts at digit 0 with the closed glyph on digit 0.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared glyph constants and select-vector helper for the seven-segment scanner.
package sev_seg_pkg;

    typedef logic [6:0] glyph_t;

    localparam glyph_t GLYPH_DOOR_OPEN   = 7'b1000011;
    localparam glyph_t GLYPH_DOOR_CLOSED = 7'b0100011;
    localparam glyph_t GLYPH_BLANK       = 7'b1111111;

    localparam int MAX_DIGITS = 32;

    // Active-low one-hot: bit idx low when idx < n, every other bit high.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input int unsigned idx, input int unsigned n);
        logic [MAX_DIGITS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i == idx && i < n) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/sev_seg_scan_timer.sv
// Slot/frame timebase for the display scanner; blink phase only with SEVSEG_BLINK_EN.
module sev_seg_scan_timer
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          moving_i,
    output logic                          slot_tick_o,
    output logic                          frame_tick_o,
    output logic                          lit_o,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx_o,
    output logic                          blink_on_o
);

    localparam int FLOOR_W = $clog2(NUM_DIGITS);
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [FLOOR_W-1:0] SCAN_LAST = FLOOR_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [FLOOR_W-1:0] scan_idx_q, scan_idx_d;
    logic               slot_tick, frame_tick, lit;

    assign slot_tick  = (div_cnt_q == DIV_LAST);
    assign frame_tick = slot_tick && (scan_idx_q == SCAN_LAST);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign lit = 1'b1;
        end else begin : g_blank
            assign lit = (32'(div_cnt_q) >= 32'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        div_cnt_d  = div_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (slot_tick) begin
            div_cnt_d  = '0;
            scan_idx_d = (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            scan_idx_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FRAME_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_on_q, blink_on_d;

    // A stationary car keeps the glyph steady and restarts the blink phase.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (!moving_i) begin
            frame_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_on_o = blink_on_q;
`else
    localparam int blink_frames_unused = BLINK_FRAMES;
    logic moving_unused;
    assign moving_unused = moving_i;
    assign blink_on_o    = 1'b1;
`endif

    assign slot_tick_o  = slot_tick;
    assign frame_tick_o = frame_tick;
    assign lit_o        = lit;
    assign scan_idx_o   = scan_idx_q;

endmodule

// File: rtl/sev_seg_scan.sv
// Multiplexed common-anode floor/door display; optional moving-car blink via SEVSEG_BLINK_EN.
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          update,
    input  logic [$clog2(NUM_DIGITS)-1:0] floor_sel,
    input  logic                          door_open,
    input  logic                          moving,
    output logic [6:0]                    segments,
    output logic [NUM_DIGITS-1:0]         select,
    output logic                          err
);

    localparam int FLOOR_W = $clog2(NUM_DIGITS);

    logic               slot_tick, frame_tick, lit, blink_on;
    logic [FLOOR_W-1:0] scan_idx;

    sev_seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .moving_i     (moving),
        .slot_tick_o  (slot_tick),
        .frame_tick_o (frame_tick),
        .lit_o        (lit),
        .scan_idx_o   (scan_idx),
        .blink_on_o   (blink_on)
    );

    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  door_q, door_d;
    glyph_t                seg_q, seg_d;
    logic [NUM_DIGITS-1:0] select_q, select_d;
    logic                  err_q, err_d;

    logic [31:0]           floor_ext;
    logic                  floor_ok;
    logic [MAX_DIGITS-1:0] onehot;

    assign floor_ext = 32'(floor_sel);
    assign floor_ok  = (floor_ext < 32'(NUM_DIGITS));
    assign onehot    = onehot_n(32'(scan_idx), 32'(NUM_DIGITS));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
            assign select_d[gi] = lit ? onehot[gi] : 1'b1;
        end
        if (NUM_DIGITS < MAX_DIGITS) begin : g_hi
            logic hi_unused;
            assign hi_unused = &onehot[MAX_DIGITS-1:NUM_DIGITS];
        end
    endgenerate

    // An out-of-range floor leaves both floor and door untouched.
    always_comb begin
        floor_d = floor_q;
        door_d  = door_q;
        err_d   = 1'b0;
        if (update) begin
            if (floor_ok) begin
                floor_d = floor_sel;
                door_d  = door_open;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        seg_d = GLYPH_BLANK;
        if (lit && blink_on && (scan_idx == floor_q)) begin
            seg_d = door_q ? GLYPH_DOOR_OPEN : GLYPH_DOOR_CLOSED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            floor_q  <= '0;
            door_q   <= 1'b0;
            seg_q    <= GLYPH_BLANK;
            select_q <= '1;
            err_q    <= 1'b0;
        end else begin
            floor_q  <= floor_d;
            door_q   <= door_d;
            seg_q    <= seg_d;
            select_q <= select_d;
            err_q    <= err_d;
        end
    end

    logic ticks_unused;
    assign ticks_unused = slot_tick ^ frame_tick;

    assign segments = seg_q;
    assign select   = select_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Scoreboard bench: stimulus queues expected display words, a negedge monitor compares them.
module tb_sev_seg_scan;

    localparam logic [6:0] G_OPEN   = 7'b1000011;
    localparam logic [6:0] G_CLOSED = 7'b0100011;
    localparam logic [6:0] G_BLANK  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       upd4 = 1'b0, upd3 = 1'b0;
    logic       door4 = 1'b0, door3 = 1'b0;
    logic       mov4 = 1'b0, mov3 = 1'b0;
    logic [1:0] fsel4 = 2'd0, fsel3 = 2'd0;
    logic [6:0] seg4, seg3;
    logic [3:0] sel4;
    logic [2:0] sel3;
    logic       err4, err3;

    always #5 clk = ~clk;

    sev_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)) dut4 (
        .clk(clk), .rst(rst), .update(upd4), .floor_sel(fsel4), .door_open(door4),
        .moving(mov4), .segments(seg4), .select(sel4), .err(err4)
    );

    sev_seg_scan #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)) dut3 (
        .clk(clk), .rst(rst), .update(upd3), .floor_sel(fsel3), .door_open(door3),
        .moving(mov3), .segments(seg3), .select(sel3), .err(err3)
    );

    typedef struct {
        int         cyc;
        int         k;
        logic [3:0] sel;
        logic [6:0] seg;
        logic       err;
        string      tag;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    string phase = "reset";

    // Expected model: c is the scan cycle (since reset release) sampled at the next edge.
    int   c = 0;
    int   floor_m [2] = '{0, 0};
    logic door_m  [2] = '{1'b0, 1'b0};
    logic vis_m = 1'b1;
    int   fc_m = 0;

    logic [3:0] scan_tbl [20] = '{
        4'b1111, 4'b1110, 4'b1110, 4'b1110,
        4'b1111, 4'b1101, 4'b1101, 4'b1101,
        4'b1111, 4'b1011, 4'b1011, 4'b1011,
        4'b1111, 4'b0111, 4'b0111, 4'b0111,
        4'b1111, 4'b1110, 4'b1110, 4'b1110
    };

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            item_t      it;
            logic [3:0] a_sel;
            logic [6:0] a_seg;
            logic       a_err;
            it = sb.pop_front();
            if (it.k == 0) begin
                a_sel = sel4; a_seg = seg4; a_err = err4;
            end else begin
                a_sel = {1'b1, sel3}; a_seg = seg3; a_err = err3;
            end
            total = total + 1;
            if (a_sel !== it.sel || a_seg !== it.seg || a_err !== it.err) begin
                bad = bad + 1;
                $display("FAIL %s cyc=%0d dut%0d: got sel=%b seg=%b err=%b, want sel=%b seg=%b err=%b",
                         it.tag, cyc, (it.k == 0) ? 4 : 3, a_sel, a_seg, a_err, it.sel, it.seg, it.err);
            end
        end
    end

    function automatic item_t predict(int k, logic ovr, logic [3:0] ovr_sel);
        item_t p;
        int    nd;
        int    slot;
        logic  lit;
        logic  vis;
        nd   = (k == 0) ? 4 : 3;
        slot = (c / 4) % nd;
        lit  = (c % 4) >= 1;
        vis  = (k == 0) ? vis_m : 1'b1;
        p.cyc = cyc + 1;
        p.k   = k;
        p.tag = phase;
        if (rst) begin
            p.sel = 4'hF;
            p.seg = G_BLANK;
            p.err = 1'b0;
        end else begin
            p.sel = lit ? (4'hF & ~(4'b0001 << slot)) : 4'hF;
            p.seg = (lit && slot == floor_m[k] && vis) ? (door_m[k] ? G_OPEN : G_CLOSED) : G_BLANK;
            if (ovr) begin
                p.sel = ovr_sel;
                p.seg = (ovr_sel == 4'b1110) ? G_CLOSED : G_BLANK;
            end
            if (k == 0) p.err = upd4 && (32'(fsel4) >= 32'd4);
            else        p.err = upd3 && (32'(fsel3) >= 32'd3);
        end
        return p;
    endfunction

    task automatic step(input logic ovr, input logic [3:0] ovr_sel);
        sb.push_back(predict(0, ovr, ovr_sel));
        sb.push_back(predict(1, 1'b0, 4'h0));
        @(posedge clk);
        #1;
        if (rst) begin
            c = 0;
            floor_m[0] = 0; floor_m[1] = 0;
            door_m[0] = 1'b0; door_m[1] = 1'b0;
            vis_m = 1'b1;
            fc_m = 0;
        end else begin
            if (upd4 && 32'(fsel4) < 32'd4) begin
                floor_m[0] = int'(fsel4); door_m[0] = door4;
            end
            if (upd3 && 32'(fsel3) < 32'd3) begin
                floor_m[1] = int'(fsel3); door_m[1] = door3;
            end
`ifdef SEVSEG_BLINK_EN
            if (mov4) begin
                if (c % 16 == 15) begin
                    fc_m = fc_m + 1;
                    if (fc_m == 2) begin
                        fc_m = 0;
                        vis_m = ~vis_m;
                    end
                end
            end else begin
                fc_m = 0;
                vis_m = 1'b1;
            end
`endif
            c = c + 1;
        end
        upd4 = 1'b0;
        upd3 = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0);
    endtask

    task automatic issue(input int k, input logic [1:0] f, input logic d);
        if (k == 0) begin
            upd4 = 1'b1; fsel4 = f; door4 = d;
        end else begin
            upd3 = 1'b1; fsel3 = f; door3 = d;
        end
        $display("txn: dut%0d update floor=%0d door=%0d at cyc %0d", (k == 0) ? 4 : 3, f, d, cyc);
    endtask

    initial begin
        phase = "reset";
        rst = 1'b1;
        run(2);
        rst = 1'b0;

        phase = "scan_order";
        for (int i = 0; i < 20; i++) step(1'b1, scan_tbl[i]);

        phase = "valid_update";
        issue(0, 2'd2, 1'b1);
        issue(1, 2'd3, 1'b1);
        step(1'b0, 4'h0);
        run(16);

        phase = "invalid_update";
        issue(1, 2'd3, 1'b0);
        step(1'b0, 4'h0);
        run(3);
        issue(1, 2'd2, 1'b0);
        step(1'b0, 4'h0);
        run(12);

        phase = "blink";
        issue(0, 2'd1, 1'b0);
        step(1'b0, 4'h0);
        for (int i = 0; i < 16 && (c % 16) != 0; i++) step(1'b0, 4'h0);
        mov4 = 1'b1;
        run(40);
        phase = "blink_stop";
        mov4 = 1'b0;
        run(20);

        phase = "reset_mid";
        issue(0, 2'd3, 1'b1);
        step(1'b0, 4'h0);
        for (int i = 0; i < 16 && (c % 16) != 9; i++) step(1'b0, 4'h0);
        rst = 1'b1;
        step(1'b0, 4'h0);
        rst = 1'b0;
        phase = "after_reset";
        run(20);

        @(negedge clk);
        #1;
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
